// File: rtl/regfile_8_scoreboard_pkg.sv
// Shared constants and types for the 8-entry register file with scoreboard.
package regfile_8_scoreboard_pkg;
  localparam int REG_ADDR_W = 3;
  localparam int NREG       = 8;
  localparam int DATA_W     = 16;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;

  localparam reg_addr_t REG_ZERO = 3'd0;
endpackage

// File: rtl/regfile_8_scoreboard_wb_decode_8.sv
// 3-to-8 write-back decode: wb_en/wb_addr to one-hot write enables.
// Shared by the data write enables and the scoreboard clear.
module wb_decode_8
  import regfile_8_scoreboard_pkg::*;
(
  input  logic            wb_en_i,
  input  reg_addr_t       wb_addr_i,
  output logic [NREG-1:0] we_o
);
  // one-hot decode, all zero when the strobe is low
  always_comb begin
    we_o = '0;
    for (int i = 0; i < NREG; i++)
      we_o[i] = wb_en_i & (wb_addr_i == reg_addr_t'(i));
  end
endmodule

// File: rtl/regfile_8_scoreboard.sv
// Eight-entry register file (R0 hardwired to zero) with a per-register
// pending-write scoreboard and two combinational read ports.
// Optional macro REGFILE_WB_BYPASS_EN forwards same-cycle write-back data
// to the read ports and masks the matching pending bit.
module regfile_8_scoreboard
  import regfile_8_scoreboard_pkg::*;
#(
  parameter int WIDTH = DATA_W
) (
  input  logic             clk,
  input  logic             rst,
  input  reg_addr_t        rs1_addr,
  input  reg_addr_t        rs2_addr,
  output logic [WIDTH-1:0] rs1_data,
  output logic [WIDTH-1:0] rs2_data,
  output logic             rs1_pending,
  output logic             rs2_pending,
  output logic             stall,
  input  logic             issue_en,
  input  reg_addr_t        issue_rd,
  input  logic             wb_en,
  input  reg_addr_t        wb_addr,
  input  logic [WIDTH-1:0] wb_data,
  output logic [NREG-1:0]  pending_vec
);
  logic [NREG-1:0]  we;
  logic [WIDTH-1:0] regs_q [NREG];
  logic [NREG-1:0]  pend_q, pend_d;
  logic [WIDTH-1:0] rd1, rd2;
  logic             pnd1, pnd2;

  wb_decode_8 u_dec (
    .wb_en_i   (wb_en),
    .wb_addr_i (wb_addr),
    .we_o      (we)
  );

  // register storage; entry 0 is cleared on reset and never written
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
    end else begin
      for (int i = 1; i < NREG; i++)
        if (we[i]) regs_q[i] <= wb_data;
    end
  end

  // scoreboard next state: issue sets (wins over same-cycle write-back), wb clears
  always_comb begin
    pend_d = pend_q;
    for (int i = 1; i < NREG; i++) begin
      if (issue_en && (issue_rd == reg_addr_t'(i))) pend_d[i] = 1'b1;
      else if (we[i])                               pend_d[i] = 1'b0;
    end
    pend_d[0] = 1'b0;
  end

  // scoreboard state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) pend_q <= '0;
    else     pend_q <= pend_d;
  end

  // stored-value reads; index 0 forced to zero
  always_comb begin
    rd1  = (rs1_addr == REG_ZERO) ? '0 : regs_q[rs1_addr];
    rd2  = (rs2_addr == REG_ZERO) ? '0 : regs_q[rs2_addr];
    pnd1 = pend_q[rs1_addr];
    pnd2 = pend_q[rs2_addr];
  end

`ifdef REGFILE_WB_BYPASS_EN
  logic hit1, hit2;

  // forward write-back data to a matching read port in the same cycle
  always_comb begin
    hit1        = wb_en && (wb_addr == rs1_addr) && (rs1_addr != REG_ZERO);
    hit2        = wb_en && (wb_addr == rs2_addr) && (rs2_addr != REG_ZERO);
    rs1_data    = hit1 ? wb_data : rd1;
    rs2_data    = hit2 ? wb_data : rd2;
    rs1_pending = hit1 ? 1'b0 : pnd1;
    rs2_pending = hit2 ? 1'b0 : pnd2;
  end
`else
  // no forwarding: stored value until the write edge, pending until cleared
  always_comb begin
    rs1_data    = rd1;
    rs2_data    = rd2;
    rs1_pending = pnd1;
    rs2_pending = pnd2;
  end
`endif

  assign stall       = rs1_pending | rs2_pending;
  assign pending_vec = pend_q;
endmodule

// File: tb/tb_regfile_8_scoreboard.sv
// Self-checking bench for regfile_8_scoreboard: table of per-cycle vectors
// (expected values queued when driven, popped when sampled) plus hand-written
// bypass and asynchronous-reset sequences.
module tb_regfile_8_scoreboard;
  import regfile_8_scoreboard_pkg::*;

  localparam int W = 16;

  logic          clk = 1'b0;
  logic          rst;
  reg_addr_t     rs1_addr, rs2_addr, issue_rd, wb_addr;
  logic [W-1:0]  rs1_data, rs2_data, wb_data;
  logic          rs1_pending, rs2_pending, stall, issue_en, wb_en;
  logic [7:0]    pending_vec;

  regfile_8_scoreboard #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_data(rs1_data), .rs2_data(rs2_data),
    .rs1_pending(rs1_pending), .rs2_pending(rs2_pending), .stall(stall),
    .issue_en(issue_en), .issue_rd(issue_rd),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .pending_vec(pending_vec)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         ie;  reg_addr_t ird;
    logic         we;  reg_addr_t wa;  logic [W-1:0] wd;
    reg_addr_t    a1;  reg_addr_t a2;
    logic [W-1:0] d1;  logic [W-1:0] d2;
    logic         p1;  logic p2;  logic st;  logic [7:0] vec;
  } vec_t;

  typedef struct {
    logic [W-1:0] d1, d2; logic p1, p2, st; logic [7:0] vec;
  } exp_t;

  int n_chk = 0;
  int n_fail = 0;
  vec_t tbl[12];
  exp_t sb_q[$];

  function automatic vec_t mk(logic ie, reg_addr_t ird, logic we, reg_addr_t wa,
                              logic [W-1:0] wd, reg_addr_t a1, reg_addr_t a2,
                              logic [W-1:0] d1, logic [W-1:0] d2,
                              logic p1, logic p2, logic st, logic [7:0] vec);
    vec_t v;
    v.ie = ie; v.ird = ird; v.we = we; v.wa = wa; v.wd = wd;
    v.a1 = a1; v.a2 = a2; v.d1 = d1; v.d2 = d2;
    v.p1 = p1; v.p2 = p2; v.st = st; v.vec = vec;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic idle();
    issue_en = 1'b0; issue_rd = '0; wb_en = 1'b0; wb_addr = '0; wb_data = '0;
  endtask

  initial begin
    // cycle-by-cycle vectors; expectations are outputs before the edge
    //            ie ird we wa wd       a1 a2 d1       d2       p1 p2 st vec
    tbl[0]  = mk(0, 0, 1, 0, 16'hBEEF, 0, 0, 16'h0,   16'h0,   0, 0, 0, 8'h00); // wb to R0
    tbl[1]  = mk(1, 3, 0, 0, 16'h0,    0, 0, 16'h0,   16'h0,   0, 0, 0, 8'h00); // issue r3
    tbl[2]  = mk(0, 0, 0, 0, 16'h0,    3, 0, 16'h0,   16'h0,   1, 0, 1, 8'h08);
    tbl[3]  = mk(0, 0, 1, 3, 16'h1234, 0, 0, 16'h0,   16'h0,   0, 0, 0, 8'h08); // wb r3
    tbl[4]  = mk(0, 0, 0, 0, 16'h0,    3, 0, 16'h1234,16'h0,   0, 0, 0, 8'h00);
    tbl[5]  = mk(1, 5, 1, 5, 16'h00AA, 3, 0, 16'h1234,16'h0,   0, 0, 0, 8'h00); // issue+wb r5
    tbl[6]  = mk(0, 0, 0, 0, 16'h0,    5, 3, 16'h00AA,16'h1234,1, 0, 1, 8'h20);
    tbl[7]  = mk(1, 2, 0, 0, 16'h0,    5, 0, 16'h00AA,16'h0,   1, 0, 1, 8'h20); // issue r2
    tbl[8]  = mk(0, 0, 1, 4, 16'h4444, 0, 0, 16'h0,   16'h0,   0, 0, 0, 8'h24); // wb non-pending r4
    tbl[9]  = mk(0, 0, 0, 0, 16'h0,    4, 2, 16'h4444,16'h0,   0, 1, 1, 8'h24);
    tbl[10] = mk(1, 5, 0, 0, 16'h0,    0, 0, 16'h0,   16'h0,   0, 0, 0, 8'h24); // reissue r5
    tbl[11] = mk(0, 0, 0, 0, 16'h0,    5, 0, 16'h00AA,16'h0,   1, 0, 1, 8'h24);

    rst = 1'b1; idle(); rs1_addr = '0; rs2_addr = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // reset state: every address reads zero, no pending, no stall
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      rs1_addr = reg_addr_t'(i); rs2_addr = reg_addr_t'(7 - i);
      #2;
      chk("rst_rs1_data", rs1_data, 0);
      chk("rst_rs2_data", rs2_data, 0);
      chk("rst_stall", stall, 0);
      chk("rst_vec", pending_vec, 0);
    end

    // table vectors through the scoreboard queue
    for (int k = 0; k < 12; k++) begin
      exp_t e;
      @(negedge clk);
      issue_en = tbl[k].ie; issue_rd = tbl[k].ird;
      wb_en = tbl[k].we; wb_addr = tbl[k].wa; wb_data = tbl[k].wd;
      rs1_addr = tbl[k].a1; rs2_addr = tbl[k].a2;
      e.d1 = tbl[k].d1; e.d2 = tbl[k].d2; e.p1 = tbl[k].p1; e.p2 = tbl[k].p2;
      e.st = tbl[k].st; e.vec = tbl[k].vec;
      sb_q.push_back(e);
      #2;
      if (sb_q.size() == 0) begin
        chk("sb_underflow", 1, 0);
      end else begin
        e = sb_q.pop_front();
        chk($sformatf("v%0d_rs1_data", k), rs1_data, e.d1);
        chk($sformatf("v%0d_rs2_data", k), rs2_data, e.d2);
        chk($sformatf("v%0d_rs1_pend", k), rs1_pending, e.p1);
        chk($sformatf("v%0d_rs2_pend", k), rs2_pending, e.p2);
        chk($sformatf("v%0d_stall", k), stall, e.st);
        chk($sformatf("v%0d_vec", k), pending_vec, e.vec);
      end
    end

    // same-cycle write-back to a pending register being read
    @(negedge clk);
    idle(); wb_en = 1'b1; wb_addr = 3'd2; wb_data = 16'h5A5A;
    rs1_addr = 3'd0; rs2_addr = 3'd2;
    #2;
`ifdef REGFILE_WB_BYPASS_EN
    chk("byp_rs2_data", rs2_data, 16'h5A5A);
    chk("byp_rs2_pend", rs2_pending, 0);
    chk("byp_stall", stall, 0);
`else
    chk("byp_rs2_data", rs2_data, 16'h0000);
    chk("byp_rs2_pend", rs2_pending, 1);
    chk("byp_stall", stall, 1);
`endif
    chk("byp_vec", pending_vec, 8'h24);
    @(negedge clk);
    idle();
    #2;
    chk("post_wb_rs2_data", rs2_data, 16'h5A5A);
    chk("post_wb_stall", stall, 0);
    chk("post_wb_vec", pending_vec, 8'h20);

    // fill the scoreboard, then reset mid-cycle
    for (int i = 1; i < 8; i++) begin
      @(negedge clk);
      issue_en = 1'b1; issue_rd = reg_addr_t'(i);
    end
    @(negedge clk);
    idle(); rs1_addr = 3'd3; rs2_addr = 3'd5;
    #1;
    chk("full_vec", pending_vec, 8'hFE);
    chk("full_rs1_data", rs1_data, 16'h1234);
    chk("full_rs2_data", rs2_data, 16'h00AA);
    chk("full_stall", stall, 1);
    rst = 1'b1;
    #1;
    chk("arst_vec", pending_vec, 8'h00);
    chk("arst_rs1_data", rs1_data, 0);
    chk("arst_rs2_data", rs2_data, 0);
    chk("arst_rs1_pend", rs1_pending, 0);
    chk("arst_rs2_pend", rs2_pending, 0);
    chk("arst_stall", stall, 0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 1; i < 8; i++) begin
      @(negedge clk);
      rs1_addr = reg_addr_t'(i); rs2_addr = reg_addr_t'(i);
      #2;
      chk($sformatf("after_rst_r%0d", i), rs1_data, 0);
      chk($sformatf("after_rst_p%0d", i), rs2_pending, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  // global watchdog
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end
endmodule
